// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_XFER      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam int DEF_INHIBIT_CYCLES = 10000;
  localparam int DEF_TIMEOUT_CYCLES = 2000000;
  localparam int DEF_FILTER_LEN     = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake between a client and the PS/2 transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       tx_busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_error, tx_busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_error, tx_busy
  );

endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : 2-flop synchronizer, glitch filter and falling-edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk_p,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int c_cnt_w = $clog2(FILTER_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync[1];
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter with ACK and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic          clk_p,
  input  logic          reset,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int c_inh_w   = $clog2(INHIBIT_CYCLES + 1);
  localparam int c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_bit_w   = $clog2(PS2_FRAME_BITS + 1);
  localparam int c_inh_pre_i = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;

  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_inh_w-1:0] c_inh_pre  = c_inh_w'(c_inh_pre_i);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_bit_w-1:0] c_par_idx  = c_bit_w'(PS2_FRAME_BITS - 3);

  ps2_state_t         r_state;
  logic [c_inh_w-1:0] r_inh_cnt;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [c_bit_w-1:0] r_bit;
  logic [7:0]         r_data;
  logic               r_parity;
  logic               r_clk_oe;
  logic               r_data_oe;
  logic               r_done;
  logic               r_error;

  logic w_clk_level;
  logic w_clk_fall;
  logic w_data_level;
  // The data line is only ever sampled as a level.
  logic w_data_fall_unused;
  logic w_timeout;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk_p   (clk_p),
    .reset   (reset),
    .i_line  (ps2_clk_i),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
    .clk_p   (clk_p),
    .reset   (reset),
    .i_line  (ps2_data_i),
    .o_level (w_data_level),
    .o_fall  (w_data_fall_unused)
  );

  assign w_timeout = (r_to_cnt == c_to_last);

  always_ff @(posedge clk_p) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (host.tx_valid) begin
            r_data    <= host.tx_data;
            r_parity  <= odd_parity(host.tx_data);
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_data_oe <= (INHIBIT_CYCLES == 1);
            r_state   <= ST_INHIBIT;
          end
        end

        // Start bit is asserted one cycle ahead so it overlaps the last inhibit cycle.
        ST_INHIBIT: begin
          if (r_inh_cnt == c_inh_last) begin
            r_clk_oe <= 1'b0;
            r_to_cnt <= '0;
            r_bit    <= '0;
            r_state  <= ST_XFER;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
            if (INHIBIT_CYCLES >= 2 && r_inh_cnt == c_inh_pre) begin
              r_data_oe <= 1'b1;
            end
          end
        end

        ST_XFER, ST_ACK: begin
          if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_clk_fall) begin
              if (r_state == ST_ACK) begin
                if (!w_data_level) begin
                  r_state <= ST_WAIT_IDLE;
                end else begin
                  r_error <= 1'b1;
                  r_state <= ST_IDLE;
                end
              end else if (r_bit < c_par_idx) begin
                r_data_oe <= ~r_data[r_bit[2:0]];
                r_bit     <= r_bit + 1'b1;
              end else if (r_bit == c_par_idx) begin
                r_data_oe <= ~r_parity;
                r_bit     <= r_bit + 1'b1;
              end else begin
                r_data_oe <= 1'b0;
                r_state   <= ST_ACK;
              end
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (w_clk_level && w_data_level) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign host.tx_ready = (r_state == ST_IDLE);
  assign host.tx_busy  = (r_state != ST_IDLE);
  assign host.tx_done  = r_done;
  assign host.tx_error = r_error;
  assign ps2_clk_oe    = r_clk_oe;
  assign ps2_data_oe   = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Directed bench for ps2_host_tx with a simple PS/2 device model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 3000;
  localparam int FL   = 4;
  localparam int HALF = 15;

  logic clk_p = 1'b0;
  logic reset = 1'b1;
  always #5 clk_p = ~clk_p;

  ps2_host_tx_if host_if ();

  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_i, ps2_data_i;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch       = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk_p       (clk_p),
    .reset       (reset),
    .host        (host_if),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0, err_seen = 0, both_seen = 0, err_oe_bad = 0;

  always @(negedge clk_p) begin
    if (host_if.tx_done === 1'b1) done_seen++;
    if (host_if.tx_error === 1'b1) err_seen++;
    if (host_if.tx_done === 1'b1 && host_if.tx_error === 1'b1) both_seen++;
    if (host_if.tx_error === 1'b1 && (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)) err_oe_bad++;
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 400 && host_if.tx_ready !== 1'b1; i++) @(negedge clk_p);
    checks++;
    if (host_if.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready: tx_ready=%b, required 1", name, host_if.tx_ready);
    end
  endtask

  task automatic do_accept(input string name, input logic [7:0] d);
    wait_ready(name);
    host_if.tx_data  = d;
    host_if.tx_valid = 1'b1;
    @(negedge clk_p);
    host_if.tx_valid = 1'b0;
    checks++;
    if (host_if.tx_ready !== 1'b0 || host_if.tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: ready=%b busy=%b clk_oe=%b, required 0 1 1",
               name, host_if.tx_ready, host_if.tx_busy, ps2_clk_oe);
    end
  endtask

  // Device model: counts inhibit, then clocks 11 pulses, sampling data after each rise.
  task automatic run_device(input bit ack, input int glitch_k, input int abort_k,
                            output logic [10:0] bits, output int inh_len, output int ov);
    bits    = '1;
    inh_len = 0;
    ov      = 0;
    for (int i = 0; i < INH + 100 && ps2_clk_oe === 1'b1; i++) begin
      inh_len++;
      if (ps2_data_oe === 1'b1) ov++;
      @(negedge clk_p);
    end
    repeat (20) @(negedge clk_p);
    bits[0] = ps2_data_i;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_p);
      dev_clk_low = 1'b0;
      if (k == abort_k) return;
      if (k <= 10) bits[k] = ps2_data_i;
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        glitch = (k == glitch_k) && (j == 4 || j == 9);
        @(negedge clk_p);
      end
      glitch = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    host_if.tx_valid = 1'b0;
    host_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk_p);
    checks++;
    if (host_if.tx_ready !== 1'b1 || host_if.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b, required 1 0", host_if.tx_ready, host_if.tx_busy);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    checks++;
    if (host_if.tx_done !== 1'b0 || host_if.tx_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: done=%b error=%b, required 0 0", host_if.tx_done, host_if.tx_error);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_p);
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic par, input int glitch_k);
    logic [10:0] bits;
    int inh, ov, d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    do_accept(name, d);
    run_device(1'b1, glitch_k, 0, bits, inh, ov);
    wait_ready(name);
    repeat (2) @(negedge clk_p);
    checks++;
    if (inh != INH || ov != 1) begin
      errors++;
      $display("FAIL %s_inhibit: len=%0d overlap=%0d, required %0d 1", name, inh, ov, INH);
    end
    checks++;
    if (bits[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: got %b, required 0", name, bits[0]);
    end
    checks++;
    if (bits[8:1] !== d) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, bits[8:1], d);
    end
    checks++;
    if (bits[9] !== par) begin
      errors++;
      $display("FAIL %s_parity: got %b, required %b", name, bits[9], par);
    end
    checks++;
    if (bits[10] !== 1'b1) begin
      errors++;
      $display("FAIL %s_stop: got %b, required 1", name, bits[10]);
    end
    checks++;
    if (done_seen - d0 != 1 || err_seen - e0 != 0) begin
      errors++;
      $display("FAIL %s_result: done=%0d error=%0d, required 1 0", name, done_seen - d0, err_seen - e0);
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    int inh, ov, d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    do_accept("nack", 8'h3C);
    run_device(1'b0, 0, 0, bits, inh, ov);
    wait_ready("nack");
    repeat (2) @(negedge clk_p);
    checks++;
    if (bits[8:1] !== 8'h3C || bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL nack_frame: data=%h par=%b, required 3c 1", bits[8:1], bits[9]);
    end
    checks++;
    if (err_seen - e0 != 1 || done_seen - d0 != 0) begin
      errors++;
      $display("FAIL nack_result: error=%0d done=%0d, required 1 0", err_seen - e0, done_seen - d0);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL nack_oe: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
  endtask

  // Device never clocks; tx_valid is held high while busy and must be ignored.
  task automatic test_timeout();
    int t;
    do_accept("timeout", 8'h5A);
    host_if.tx_data  = 8'h00;
    host_if.tx_valid = 1'b1;
    for (int i = 0; i < INH + 100 && ps2_clk_oe === 1'b1; i++) @(negedge clk_p);
    t = 0;
    while (t < TO + 50 && host_if.tx_error !== 1'b1) begin
      @(negedge clk_p);
      t++;
    end
    host_if.tx_valid = 1'b0;
    checks++;
    if (t != TO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", t, TO);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || host_if.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: clk_oe=%b data_oe=%b ready=%b, required 0 0 1",
               ps2_clk_oe, ps2_data_oe, host_if.tx_ready);
    end
    repeat (3) @(negedge clk_p);
    checks++;
    if (host_if.tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: ready=%b clk_oe=%b, required 1 0", host_if.tx_ready, ps2_clk_oe);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    int inh, ov;
    do_accept("rstmid", 8'h96);
    run_device(1'b1, 0, 4, bits, inh, ov);
    checks++;
    if (host_if.tx_busy !== 1'b1 || ps2_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: busy=%b data_oe=%b, required 1 1", host_if.tx_busy, ps2_data_oe);
    end
    reset = 1'b1;
    @(negedge clk_p);
    reset = 1'b0;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || host_if.tx_ready !== 1'b1 || host_if.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: clk_oe=%b data_oe=%b ready=%b busy=%b, required 0 0 1 0",
               ps2_clk_oe, ps2_data_oe, host_if.tx_ready, host_if.tx_busy);
    end
    repeat (10) @(negedge clk_p);
    test_frame("after_rst_f4", 8'hF4, 1'b0, 0);
  endtask

  initial begin
    @(negedge clk_p);
    test_reset();
    test_frame("ed", 8'hED, 1'b1, 0);
    test_frame("x01", 8'h01, 1'b0, 0);
    test_frame("xff", 8'hFF, 1'b1, 0);
    test_nack();
    test_timeout();
    test_reset_mid();
    test_frame("glitch_a5", 8'hA5, 1'b1, 5);
    checks++;
    if (both_seen != 0 || err_oe_bad != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: both=%0d err_with_oe=%0d, required 0 0", both_seen, err_oe_bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clock-low inhibit time (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum time from clock release to acknowledge bit (20 ms).
REQ-003 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal synchronized samples needed to accept a PS/2 clock level.
REQ-004 clk_p  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  command byte to send to the device.
REQ-007 tx_valid  input  1  request; accepted when tx_valid and tx_ready are both high.
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 tx_done  output  1  one-cycle pulse on successful acknowledge.
REQ-010 tx_error  output  1  one-cycle pulse on NACK or timeout.
REQ-011 tx_busy  output  1  high in every state except IDLE; receiver ignores the bus while high.
REQ-012 ps2_clk_i, ps2_data_i  input  1 each  raw open-drain line levels.
REQ-013 ps2_clk_oe, ps2_data_oe  output  1 each  high pulls the line low; low releases it.

Function
REQ-014 SHALL pass ps2_clk_i and ps2_data_i through 2-flop synchronizers.
REQ-015 Filtered clock SHALL change only after FILTER_LEN equal samples; a falling edge is a filtered 1->0 transition.
REQ-016 States SHALL be IDLE, INHIBIT, XFER, ACK, WAIT_IDLE.
REQ-017 IDLE: on accept, latch tx_data and compute odd parity (~^tx_data), then enter INHIBIT; oe outputs low.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
REQ-019 In the final INHIBIT cycle, ps2_data_oe SHALL assert (start bit); the next cycle SHALL release ps2_clk_oe and enter XFER with bit index 0.
REQ-020 XFER: on falling edges 1..8, drive data bit 0..7, LSB first (oe=~bit).
REQ-021 XFER: on falling edge 9, drive the parity bit; on falling edge 10, release data (stop bit) and enter ACK.
REQ-022 ACK: on the next falling edge, sample filtered data. 0 -> WAIT_IDLE. 1 -> tx_error pulse, then IDLE.
REQ-023 WAIT_IDLE: when filtered clock and data are both high, pulse tx_done and enter IDLE.
REQ-024 Timeout counter SHALL start at clock release and stop when ACK exits. Reaching TIMEOUT_CYCLES in XFER or ACK SHALL release both oe, pulse tx_error and enter IDLE.
REQ-025 tx_valid while not ready SHALL be ignored; no queueing.
REQ-026 tx_done and tx_error SHALL never assert in the same cycle.
REQ-027 Counter widths SHALL be $clog2(param+1); no counter SHALL wrap.

Reset
REQ-028 Reset SHALL, from any state including mid-transfer, set state=IDLE and counters=0.
REQ-029 Reset SHALL clear tx_done, tx_error, ps2_clk_oe and ps2_data_oe; tx_busy SHALL be 0 and tx_ready SHALL be 1 from the next cycle.
REQ-030 Synchronizers and filter SHALL reset to 1 (idle bus).

Structure
REQ-031 Shared package ps2_pkg SHALL hold the state enum, PS2_FRAME_BITS=11 and default parameter constants.
REQ-032 Sub-module ps2_line_sync SHALL implement one synchronizer, glitch filter and falling-edge detector; it is instantiated twice (clock, data).

Verification
REQ-033 tx_data=0xED, device model ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop released; tx_done once; tx_error never.
REQ-034 tx_data=0x01 -> parity bit 0; tx_data=0xFF -> parity bit 1.
REQ-035 Device model leaves data high at ack -> tx_error one cycle, tx_done 0, both oe low, then IDLE.
REQ-036 Device never clocks -> tx_error exactly TIMEOUT_CYCLES after clock release; lines released.
REQ-037 Reset asserted after falling edge 4 -> oe outputs low and tx_ready=1 next cycle; a subsequent 0xF4 completes normally.
REQ-038 1-cycle glitches on ps2_clk_i (shorter than FILTER_LEN) during XFER -> no bit advance; the frame still completes correctly.
